// File: rtl/writeback_arbiter.sv
// Writeback arbiter. The ALU and the LSU each feed a small in-order result FIFO.
// Every cycle one FIFO head is chosen, either round-robin or LSU-first, and is
// loaded into a registered register-file write port. pending_mask tells decode
// which destination registers still have a result in flight.
module writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter bit LSU_PRIORITY = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd_id,
  input  logic [31:0] alu_val,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd_id,
  input  logic [31:0] lsu_val,
  output logic        is_writing_rd,
  output logic [4:0]  rd_reg_id,
  output logic [31:0] rd_val,
  output logic [31:0] pending_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Source index 0 is the ALU and index 1 is the LSU.
  // The pointers are one bit wider than the index, so full and empty can be told apart.
  logic [4:0]  id_q   [2][DEPTH];
  logic [4:0]  id_d   [2][DEPTH];
  logic [31:0] val_q  [2][DEPTH];
  logic [31:0] val_d  [2][DEPTH];
  logic [AW:0] wptr_q [2];
  logic [AW:0] wptr_d [2];
  logic [AW:0] rptr_q [2];
  logic [AW:0] rptr_d [2];
  logic        rr_q, rr_d;           // 0: ALU is favoured, 1: LSU is favoured
  logic        wr_q, wr_d;
  logic [4:0]  rd_id_q, rd_id_d;
  logic [31:0] rd_val_q, rd_val_d;

  logic        in_valid_s [2];
  logic [4:0]  in_id_s    [2];
  logic [31:0] in_val_s   [2];
  logic [1:0]  empty_s, full_s, ready_s, enq_s, pop_s;
  logic [31:0] mask_s;

  function automatic logic fifo_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  assign in_valid_s[0] = alu_valid;
  assign in_valid_s[1] = lsu_valid;
  assign in_id_s[0]    = alu_rd_id;
  assign in_id_s[1]    = lsu_rd_id;
  assign in_val_s[0]   = alu_val;
  assign in_val_s[1]   = lsu_val;

  // FIFO status and handshake. Ready uses only the pre-edge state; a write to r0 is accepted but not kept.
  always_comb begin
    empty_s = 2'b00;
    full_s  = 2'b00;
    ready_s = 2'b00;
    enq_s   = 2'b00;
    for (int s = 0; s < 2; s++) begin
      empty_s[s] = (wptr_q[s] == rptr_q[s]);
      full_s[s]  = fifo_full(wptr_q[s], rptr_q[s]);
      ready_s[s] = rdy_in & ~flush_pipline & ~full_s[s];
      enq_s[s]   = in_valid_s[s] & ready_s[s] & (in_id_s[s] != 5'd0);
    end
  end

  // Arbitration: a lone non-empty source wins; on contention use priority or the round-robin pointer.
  always_comb begin
    pop_s = 2'b00;
    rr_d  = rr_q;
    if (rdy_in && !flush_pipline) begin
      if (!empty_s[0] && !empty_s[1]) begin
        if (LSU_PRIORITY) begin
          pop_s = 2'b10;
        end else begin
          pop_s = rr_q ? 2'b10 : 2'b01;
          rr_d  = ~rr_q;
        end
      end else begin
        pop_s = ~empty_s;
      end
    end else begin
      pop_s = 2'b00;
    end
  end

  // Next state for the FIFOs and the output stage. A freeze holds everything; a flush empties the FIFOs.
  always_comb begin
    id_d     = id_q;
    val_d    = val_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wr_d     = wr_q;
    rd_id_d  = rd_id_q;
    rd_val_d = rd_val_q;
    if (!rdy_in) begin
      wr_d = wr_q;
    end else if (flush_pipline) begin
      for (int s = 0; s < 2; s++) begin
        wptr_d[s] = '0;
        rptr_d[s] = '0;
      end
      wr_d = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (enq_s[s]) begin
          id_d[s][wptr_q[s][AW-1:0]]  = in_id_s[s];
          val_d[s][wptr_q[s][AW-1:0]] = in_val_s[s];
          wptr_d[s] = wptr_q[s] + PTR_ONE;
        end else begin
          wptr_d[s] = wptr_q[s];
        end
        if (pop_s[s]) begin
          rptr_d[s] = rptr_q[s] + PTR_ONE;
        end else begin
          rptr_d[s] = rptr_q[s];
        end
      end
      if (pop_s[1]) begin
        wr_d     = 1'b1;
        rd_id_d  = id_q[1][rptr_q[1][AW-1:0]];
        rd_val_d = val_q[1][rptr_q[1][AW-1:0]];
      end else if (pop_s[0]) begin
        wr_d     = 1'b1;
        rd_id_d  = id_q[0][rptr_q[0][AW-1:0]];
        rd_val_d = val_q[0][rptr_q[0][AW-1:0]];
      end else begin
        wr_d = 1'b0;
      end
    end
  end

  // Pending-register mask: one bit per live FIFO entry plus the write currently being presented.
  always_comb begin
    logic [AW-1:0] off_v;
    logic [AW:0]   cnt_v;
    logic          live_v;
    mask_s = 32'd0;
    off_v  = '0;
    cnt_v  = '0;
    live_v = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cnt_v = wptr_q[s] - rptr_q[s];
      for (int i = 0; i < DEPTH; i++) begin
        off_v  = AW'(i) - rptr_q[s][AW-1:0];
        live_v = ({1'b0, off_v} < cnt_v);
        mask_s = mask_s | ((32'd1 << id_q[s][i]) & {32{live_v}});
      end
    end
    mask_s    = mask_s | ((32'd1 << rd_id_q) & {32{wr_q}});
    mask_s[0] = 1'b0;
  end

  // State registers with an asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          id_q[s][i]  <= 5'd0;
          val_q[s][i] <= 32'd0;
        end
      end
      rr_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_id_q  <= 5'd0;
      rd_val_q <= 32'd0;
    end else begin
      id_q     <= id_d;
      val_q    <= val_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rr_q     <= rr_d;
      wr_q     <= wr_d;
      rd_id_q  <= rd_id_d;
      rd_val_q <= rd_val_d;
    end
  end

  assign alu_ready     = ready_s[0];
  assign lsu_ready     = ready_s[1];
  assign is_writing_rd = wr_q;
  assign rd_reg_id     = rd_id_q;
  assign rd_val        = rd_val_q;
  assign pending_mask  = mask_s;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, async reset, randomized run vs queue model.
module tb_writeback_arbiter;
  localparam int DEPTH        = 2;
  localparam bit LSU_PRIORITY = 1'b0;

  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, flush_pipline = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]  alu_rd_id = 5'd0, lsu_rd_id = 5'd0;
  logic [31:0] alu_val = 32'd0, lsu_val = 32'd0;
  logic        alu_ready, lsu_ready, is_writing_rd;
  logic [4:0]  rd_reg_id;
  logic [31:0] rd_val, pending_mask;

  int n_pass = 0, n_total = 0;

  writeback_arbiter #(.DEPTH(DEPTH), .LSU_PRIORITY(LSU_PRIORITY)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_id(alu_rd_id), .alu_val(alu_val),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_id(lsu_rd_id), .lsu_val(lsu_val),
    .is_writing_rd(is_writing_rd), .rd_reg_id(rd_reg_id), .rd_val(rd_val),
    .pending_mask(pending_mask)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rdy, flush, av; logic [4:0] aid; logic [31:0] aval;
    logic lv; logic [4:0] lid; logic [31:0] lval;
    logic ewr; logic [4:0] eid; logic [31:0] eval; logic [31:0] emask; logic ear, elr;
  } vec_t;
  vec_t vecs[27];

  function automatic vec_t mk(input logic rdy, input logic fl, input logic av, input logic [4:0] aid,
                              input logic [31:0] aval, input logic lv, input logic [4:0] lid,
                              input logic [31:0] lval, input logic ewr, input logic [4:0] eid,
                              input logic [31:0] ev, input logic [31:0] em, input logic ear,
                              input logic elr);
    vec_t v;
    v.rdy = rdy; v.flush = fl; v.av = av; v.aid = aid; v.aval = aval;
    v.lv = lv; v.lid = lid; v.lval = lval;
    v.ewr = ewr; v.eid = eid; v.eval = ev; v.emask = em; v.ear = ear; v.elr = elr;
    return v;
  endfunction

  function automatic vec_t idl(input logic ewr, input logic [4:0] eid, input logic [31:0] ev,
                               input logic [31:0] em);
    return mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ewr, eid, ev, em, 1'b1, 1'b1);
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [4:0] id; logic [31:0] v; } ent_t;
  ent_t aq[$], lq[$];
  bit          m_rr;
  bit          m_wr;
  logic [4:0]  m_id;
  logic [31:0] m_val;

  function automatic logic [31:0] m_mask();
    logic [31:0] m = 32'd0;
    foreach (aq[k]) m[aq[k].id] = 1'b1;
    foreach (lq[k]) m[lq[k].id] = 1'b1;
    if (m_wr) m[m_id] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    aq.delete(); lq.delete();
    m_rr = 1'b0; m_wr = 1'b0; m_id = 5'd0; m_val = 32'd0;
  endtask

  task automatic model_edge();
    ent_t e;
    bit a_ok, l_ok;
    int take;
    if (!rdy_in) return;
    if (flush_pipline) begin
      aq.delete(); lq.delete(); m_wr = 1'b0;
      return;
    end
    a_ok = (aq.size() < DEPTH);
    l_ok = (lq.size() < DEPTH);
    take = 0;
    if (aq.size() > 0 && lq.size() > 0) begin
      if (LSU_PRIORITY) take = 2;
      else begin
        take = m_rr ? 2 : 1;
        m_rr = !m_rr;
      end
    end else if (aq.size() > 0) take = 1;
    else if (lq.size() > 0) take = 2;
    if (take == 1) e = aq.pop_front();
    else if (take == 2) e = lq.pop_front();
    if (take != 0) begin
      m_wr = 1'b1; m_id = e.id; m_val = e.v;
    end else m_wr = 1'b0;
    if (alu_valid && a_ok && alu_rd_id != 5'd0) aq.push_back({alu_rd_id, alu_val});
    if (lsu_valid && l_ok && lsu_rd_id != 5'd0) lq.push_back({lsu_rd_id, lsu_val});
  endtask

  initial begin
    // Single write, contention, r0 drop, streaming, freeze, flush, pointer kept across flush.
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h20, 1'b1, 1'b1);
    vecs[1]  = idl(1'b1, 5'd5, 32'hDEADBEEF, 32'h20);
    vecs[2]  = idl(1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd5, 32'hDEADBEEF, 32'h6, 1'b1, 1'b1);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd1, 32'h11, 32'h1E, 1'b1, 1'b0);
    vecs[5]  = idl(1'b1, 5'd2, 32'h22, 32'h1C);
    vecs[6]  = idl(1'b1, 5'd3, 32'h33, 32'h18);
    vecs[7]  = idl(1'b1, 5'd4, 32'h44, 32'h10);
    vecs[8]  = idl(1'b0, 5'd4, 32'h44, 32'h0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h44, 32'h0, 1'b1, 1'b1);
    vecs[10] = idl(1'b0, 5'd4, 32'h44, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h44, 32'h40, 1'b1, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 32'hC0, 1'b1, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 32'h180, 1'b1, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 32'h300, 1'b1, 1'b1);
    vecs[15] = idl(1'b1, 5'd9, 32'h99, 32'h200);
    for (int i = 16; i < 19; i++)
      vecs[i] = mk(1'b0, 1'b0, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 32'h200, 1'b0, 1'b0);
    vecs[19] = idl(1'b0, 5'd9, 32'h99, 32'h0);
    vecs[20] = mk(1'b1, 1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd9, 32'h99, 32'hC00, 1'b1, 1'b1);
    vecs[21] = mk(1'b1, 1'b1, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 32'h99, 32'h0, 1'b0, 1'b0);
    vecs[22] = idl(1'b0, 5'd9, 32'h99, 32'h0);
    vecs[23] = mk(1'b1, 1'b0, 1'b1, 5'd13, 32'hC1, 1'b1, 5'd14, 32'hC2, 1'b0, 5'd9, 32'h99, 32'h6000, 1'b1, 1'b1);
    vecs[24] = idl(1'b1, 5'd14, 32'hC2, 32'h6000);
    vecs[25] = idl(1'b1, 5'd13, 32'hC1, 32'h2000);
    vecs[26] = idl(1'b0, 5'd13, 32'hC1, 32'h0);

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset wr", 32'(is_writing_rd), 32'd0);
    chk("reset rd_id", 32'(rd_reg_id), 32'd0);
    chk("reset rd_val", rd_val, 32'd0);
    chk("reset mask", pending_mask, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Directed table
    for (int i = 0; i < 27; i++) begin
      rdy_in = vecs[i].rdy; flush_pipline = vecs[i].flush;
      alu_valid = vecs[i].av; alu_rd_id = vecs[i].aid; alu_val = vecs[i].aval;
      lsu_valid = vecs[i].lv; lsu_rd_id = vecs[i].lid; lsu_val = vecs[i].lval;
      @(posedge clk_in);
      #1;
      chk($sformatf("row%0d wr", i), 32'(is_writing_rd), 32'(vecs[i].ewr));
      chk($sformatf("row%0d rd_id", i), 32'(rd_reg_id), 32'(vecs[i].eid));
      chk($sformatf("row%0d rd_val", i), rd_val, vecs[i].eval);
      chk($sformatf("row%0d mask", i), pending_mask, vecs[i].emask);
      chk($sformatf("row%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      chk($sformatf("row%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].elr));
    end

    // Async reset mid-cycle while a write is being presented
    rdy_in = 1'b1; flush_pipline = 1'b0; lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd_id = 5'd15; alu_val = 32'hF0;
    @(posedge clk_in);
    #1;
    alu_valid = 1'b0;
    @(posedge clk_in);
    #1;
    chk("pre-reset wr", 32'(is_writing_rd), 32'd1);
    chk("pre-reset rd_id", 32'(rd_reg_id), 32'd15);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async reset wr", 32'(is_writing_rd), 32'd0);
    chk("async reset rd_id", 32'(rd_reg_id), 32'd0);
    chk("async reset rd_val", rd_val, 32'd0);
    chk("async reset mask", pending_mask, 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Randomized run against the queue model
    for (int c = 0; c < 600; c++) begin
      rdy_in        = ($urandom_range(0, 99) < 85);
      flush_pipline = ($urandom_range(0, 99) < 4);
      alu_valid     = ($urandom_range(0, 99) < 70);
      lsu_valid     = ($urandom_range(0, 99) < 70);
      alu_rd_id     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_rd_id     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_val       = $urandom;
      lsu_val       = $urandom;
      @(negedge clk_in);
      chk($sformatf("rnd%0d alu_ready", c), 32'(alu_ready),
          32'(rdy_in && !flush_pipline && aq.size() < DEPTH));
      chk($sformatf("rnd%0d lsu_ready", c), 32'(lsu_ready),
          32'(rdy_in && !flush_pipline && lq.size() < DEPTH));
      chk($sformatf("rnd%0d pre mask", c), pending_mask, m_mask());
      @(posedge clk_in);
      model_edge();
      #1;
      chk($sformatf("rnd%0d wr", c), 32'(is_writing_rd), 32'(m_wr));
      chk($sformatf("rnd%0d rd_id", c), 32'(rd_reg_id), 32'(m_id));
      chk($sformatf("rnd%0d rd_val", c), rd_val, m_val);
      chk($sformatf("rnd%0d mask", c), pending_mask, m_mask());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
